agc_power_monitor: RTL and testbench

//   Windowed mean-square power detector placed directly downstream of the AGC loop; consumes AGC y_out samples.

---
 rtl/agc_pkg.sv | 27 ++
 rtl/agc_win_accum.sv | 142 ++++++++++++++
 rtl/agc_power_monitor.sv | 185 ++++++++++++++++++
 tb/tb_agc_power_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// ---------------------------------------------------------------------------
// agc_pkg
//   Definitions shared between the AGC loop and its power monitor.
//   - ST_ACQ / ST_LOCKED : lock-state encodings (1-bit, legacy compatible)
//   - AGC_REF_W          : width of the AGC reference level input
//   - WIN_CNT_W          : width of the consecutive-window hit/miss counters
//   - ref_power()        : target power from the upper reference bits
// ---------------------------------------------------------------------------
package agc_pkg;

  localparam logic [0:0] ST_ACQ    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int AGC_REF_W = 16;
  localparam int WIN_CNT_W = 4;

  // The AGC compares against the square of reference[15:1]; the caller
  // passes those bits so the LSB never enters the power domain.
  function automatic logic [2*(AGC_REF_W-1)-1:0] ref_power(
    input logic [AGC_REF_W-2:0] ref_half
  );
    logic [2*(AGC_REF_W-1)-1:0] ref_ext;
    ref_ext = {{(AGC_REF_W-1){1'b0}}, ref_half};
    return ref_ext * ref_ext;
  endfunction

endpackage

// File: rtl/agc_win_accum.sv
// ---------------------------------------------------------------------------
// agc_win_accum
//   Squares each valid sample (stage 1, registered) and accumulates the
//   squares over a window of 2**WIN_LOG2 valid samples (stage 2). At the
//   window's last sample it raises done_o for one cycle together with the
//   window mean (pwr_o), the sticky saturation result (sat_o) and, when
//   AGC_PWR_PEAK_EN is defined, the peak magnitude (peak_o). These outputs
//   are combinational from the stage-2 registers; the caller registers them.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_valid_i   sample qualifier
//   x_i          signed sample
//   done_o       window complete (valid for one cycle)
//   pwr_o        (sum of squares) >> WIN_LOG2, truncated
//   sat_o        window contained the max or min code
//   peak_o       max |x_i| of the window, -2**(DATA_W-1) clamped
//                (present only with AGC_PWR_PEAK_EN)
// ---------------------------------------------------------------------------
module agc_win_accum #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic                     done_o,
  output logic [2*DATA_W-1:0]      pwr_o,
  output logic                     sat_o
`ifdef AGC_PWR_PEAK_EN
  ,
  output logic [DATA_W-1:0]        peak_o
`endif
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int ACC_W = SQ_W + WIN_LOG2;
  localparam logic [DATA_W-1:0] CODE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] CODE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------- stage 1: square ----------------
  logic [SQ_W-1:0] x_ext;
  logic [SQ_W-1:0] sq_d, sq_q;
  logic            sat1_d, sat1_q;
  logic            vld1_q;

  // The square of the sign-extended value taken modulo 2**SQ_W is the exact
  // square, since the largest result (2**(2*DATA_W-2)) fits in SQ_W bits.
  assign x_ext  = {{DATA_W{x_i[DATA_W-1]}}, x_i};
  assign sq_d   = x_ext * x_ext;
  assign sat1_d = ($unsigned(x_i) == CODE_MAX) || ($unsigned(x_i) == CODE_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      sq_q   <= '0;
      sat1_q <= 1'b0;
    end else begin
      vld1_q <= in_valid_i;
      if (in_valid_i) begin
        sq_q   <= sq_d;
        sat1_q <= sat1_d;
      end
    end
  end

  // ---------------- stage 2: accumulate ----------------
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic                sat_acc_q, sat_acc_d;

  assign acc_sum = acc_q + ACC_W'(sq_q);
  assign done_o  = vld1_q && (cnt_q == '1);
  assign pwr_o   = acc_sum[ACC_W-1:WIN_LOG2];
  assign sat_o   = sat_acc_q | sat1_q;

`ifdef AGC_PWR_PEAK_EN
  logic [DATA_W-1:0] mag_d, mag1_q;
  logic [DATA_W-1:0] peak_acc_q, peak_acc_d;

  // The most negative code has no positive twin; clamp it to the max code.
  assign mag_d  = !x_i[DATA_W-1]                  ? $unsigned(x_i) :
                  ($unsigned(x_i) == CODE_MIN)    ? CODE_MAX :
                                                    $unsigned(-x_i);
  assign peak_o = (mag1_q > peak_acc_q) ? mag1_q : peak_acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag1_q <= '0;
    end else if (in_valid_i) begin
      mag1_q <= mag_d;
    end
  end
`endif

  // Gaps in vld1_q simply hold the window state, so they never affect the result.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_acc_d = sat_acc_q;
`ifdef AGC_PWR_PEAK_EN
    peak_acc_d = peak_acc_q;
`endif
    if (vld1_q) begin
      if (done_o) begin
        // Window published this cycle; the next sample starts a fresh window.
        acc_d     = '0;
        cnt_d     = '0;
        sat_acc_d = 1'b0;
`ifdef AGC_PWR_PEAK_EN
        peak_acc_d = '0;
`endif
      end else begin
        acc_d     = acc_sum;
        cnt_d     = cnt_q + WIN_LOG2'(1);
        sat_acc_d = sat_o;
`ifdef AGC_PWR_PEAK_EN
        peak_acc_d = peak_o;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
`ifdef AGC_PWR_PEAK_EN
      peak_acc_q <= '0;
`endif
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_acc_q <= sat_acc_d;
`ifdef AGC_PWR_PEAK_EN
      peak_acc_q <= peak_acc_d;
`endif
    end
  end

endmodule

// File: rtl/agc_power_monitor.sv
// ---------------------------------------------------------------------------
// agc_power_monitor
//   Windowed mean-square power detector behind the AGC loop. Each completed
//   window of 2**WIN_LOG2 valid samples publishes its mean-square power and
//   saturation flag, compares the power against the AGC target
//   (reference[15:1]^2) and advances a lock state machine.
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   in_valid   x_in qualifier
//   x_in       signed sample (AGC y_out)
//   reference  AGC target level
//   pwr_out    mean-square of the last completed window
//   pwr_valid  one-cycle pulse when pwr_out/locked/sat_flag update
//   locked     lock state machine is in LOCKED
//   sat_flag   last window contained the max or min code
//   peak_out   max |x_in| of the last window (only with AGC_PWR_PEAK_EN)
// Configuration
//   AGC_PWR_PEAK_EN : adds peak_out and the peak tracking logic.
// ---------------------------------------------------------------------------
module agc_power_monitor
  import agc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int WIN_LOG2    = 8,
  parameter int TOL_SHIFT   = 4,
  parameter int LOCK_WINS   = 3,
  parameter int UNLOCK_WINS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [AGC_REF_W-1:0]     reference,
  output logic [2*DATA_W-1:0]      pwr_out,
  output logic                     pwr_valid,
  output logic                     locked,
  output logic                     sat_flag
`ifdef AGC_PWR_PEAK_EN
  ,
  output logic [DATA_W-1:0]        peak_out
`endif
);

  localparam int PWR_W     = 2 * DATA_W;
  localparam int REF_PWR_W = 2 * (AGC_REF_W - 1);
  localparam int CMP_W     = (PWR_W > REF_PWR_W) ? PWR_W : REF_PWR_W;
  localparam logic [WIN_CNT_W-1:0] LOCK_N   = WIN_CNT_W'(LOCK_WINS);
  localparam logic [WIN_CNT_W-1:0] UNLOCK_N = WIN_CNT_W'(UNLOCK_WINS);

  // ---------------- window accumulator ----------------
  logic             win_done;
  logic [PWR_W-1:0] win_pwr;
  logic             win_sat;
`ifdef AGC_PWR_PEAK_EN
  logic [DATA_W-1:0] win_peak;
`endif

  agc_win_accum #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_accum (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .x_i        (x_in),
    .done_o     (win_done),
    .pwr_o      (win_pwr),
    .sat_o      (win_sat)
`ifdef AGC_PWR_PEAK_EN
    ,
    .peak_o     (win_peak)
`endif
  );

  // ---------------- tolerance compare ----------------
  logic [REF_PWR_W-1:0] ref_pwr;
  logic [CMP_W-1:0]     pwr_ext, ref_ext, err, tol;
  logic                 hit;

  assign ref_pwr = ref_power(reference[AGC_REF_W-1:1]);
  assign pwr_ext = CMP_W'(win_pwr);
  assign ref_ext = CMP_W'(ref_pwr);
  assign err     = (pwr_ext >= ref_ext) ? (pwr_ext - ref_ext) : (ref_ext - pwr_ext);
  assign tol     = ref_ext >> TOL_SHIFT;
  // With ref_pwr == 0 the tolerance is 0, so only a silent window hits.
  assign hit     = (err <= tol);

  // ---------------- lock state machine ----------------
  logic [0:0]           state_q, state_d;
  logic [WIN_CNT_W-1:0] hit_q, hit_d;
  logic [WIN_CNT_W-1:0] miss_q, miss_d;
  logic [AGC_REF_W-1:0] ref_q;
  logic                 ref_seen_q;
  logic                 ref_changed;

  // The first window after reset has no earlier reference to differ from.
  assign ref_changed = ref_seen_q && (reference != ref_q);

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    if (win_done) begin
      if (ref_changed) begin
        // A new target invalidates any lock evidence gathered so far.
        state_d = ST_ACQ;
        hit_d   = '0;
        miss_d  = '0;
      end else begin
        case (state_q)
          ST_LOCKED: begin
            if (hit) begin
              miss_d = '0;
            end else if (miss_q + WIN_CNT_W'(1) == UNLOCK_N) begin
              state_d = ST_ACQ;
              hit_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + WIN_CNT_W'(1);
            end
          end
          default: begin
            if (!hit) begin
              hit_d = '0;
            end else if (hit_q + WIN_CNT_W'(1) == LOCK_N) begin
              state_d = ST_LOCKED;
              hit_d   = '0;
              miss_d  = '0;
            end else begin
              hit_d = hit_q + WIN_CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // ---------------- output registers ----------------
  logic [PWR_W-1:0] pwr_q;
  logic             pwr_valid_q;
  logic             sat_q;
`ifdef AGC_PWR_PEAK_EN
  logic [DATA_W-1:0] peak_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_q       <= '0;
      pwr_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      state_q     <= ST_ACQ;
      hit_q       <= '0;
      miss_q      <= '0;
      ref_q       <= '0;
      ref_seen_q  <= 1'b0;
`ifdef AGC_PWR_PEAK_EN
      peak_q      <= '0;
`endif
    end else begin
      pwr_valid_q <= win_done;
      state_q     <= state_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      if (win_done) begin
        pwr_q      <= win_pwr;
        sat_q      <= win_sat;
        ref_q      <= reference;
        ref_seen_q <= 1'b1;
`ifdef AGC_PWR_PEAK_EN
        peak_q     <= win_peak;
`endif
      end
    end
  end

  assign pwr_out   = pwr_q;
  assign pwr_valid = pwr_valid_q;
  assign locked    = (state_q == ST_LOCKED);
  assign sat_flag  = sat_q;
`ifdef AGC_PWR_PEAK_EN
  assign peak_out  = peak_q;
`endif

endmodule

// File: tb/tb_agc_power_monitor.sv
// ---------------------------------------------------------------------------
// tb_agc_power_monitor
//   Directed bench for agc_power_monitor with WIN_LOG2=4, TOL_SHIFT=4,
//   LOCK_WINS=3, UNLOCK_WINS=2. Expected window powers are hand-computed
//   constants; a monitor queues every pwr_valid pulse and the driver queues
//   the cycle of each window's last sample so latency can be checked.
//   Peak checks are compiled in when AGC_PWR_PEAK_EN is defined.
// ---------------------------------------------------------------------------
module tb_agc_power_monitor;

  localparam longint P8192  = 67108864;    // 8192^2
  localparam longint P4096  = 16777216;    // 4096^2
  localparam longint PMIN   = 1073741824;  // (-32768)^2
  localparam longint PMAX1  = 67104768;    // 32767^2 / 16, truncated
  localparam longint PRAMP  = 77;          // (0^2+..+15^2)=1240 / 16
  localparam longint P8444  = 71301136;    // +4192272 from 2^26: inside tol 4194304
  localparam longint P8445  = 71318025;    // +4209161: outside
  localparam longint P7932  = 62916624;    // -4192240: inside
  localparam longint P7931  = 62900761;    // -4208103: outside

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] x_in = '0;
  logic [15:0]        reference = 16'd16384;
  logic [31:0]        pwr_out;
  logic               pwr_valid;
  logic               locked;
  logic               sat_flag;
`ifdef AGC_PWR_PEAK_EN
  logic [15:0]        peak_out;
`endif

  always #5 clk = ~clk;

  agc_power_monitor #(
    .DATA_W      (16),
    .WIN_LOG2    (4),
    .TOL_SHIFT   (4),
    .LOCK_WINS   (3),
    .UNLOCK_WINS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .reference (reference),
    .pwr_out   (pwr_out),
    .pwr_valid (pwr_valid),
    .locked    (locked),
    .sat_flag  (sat_flag)
`ifdef AGC_PWR_PEAK_EN
    ,
    .peak_out  (peak_out)
`endif
  );

  typedef struct {
    longint      cyc;
    longint      pwr;
    logic        lk;
    logic        sat;
    logic [15:0] peak;
  } pv_t;

  pv_t    pvq[$];
  longint lastq[$];
  pv_t    last_rec;
  longint cyc = 0;
  int     samp_cnt = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pwr_valid pulse with the outputs published alongside it.
  always @(negedge clk) begin
    pv_t r;
    if (pwr_valid === 1'b1) begin
      r.cyc = cyc;
      r.pwr = longint'(pwr_out);
      r.lk  = locked;
      r.sat = sat_flag;
`ifdef AGC_PWR_PEAK_EN
      r.peak = peak_out;
`else
      r.peak = '0;
`endif
      pvq.push_back(r);
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Drive n valid samples of value x; with gap, each is followed by an idle
  // cycle carrying a max-code decoy on x_in that must be ignored.
  task automatic drive(input int x, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      x_in     = 16'(x);
      @(posedge clk); #1;
      samp_cnt++;
      if (samp_cnt == 16) begin
        lastq.push_back(cyc);
        samp_cnt = 0;
      end
      if (gap) begin
        in_valid = 1'b0;
        x_in     = 16'sh7FFF;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    samp_cnt = 0;
    lastq.delete();
  endtask

  // Pop the next window result; latency is measured in edges between the
  // edge sampling the last sample and the edge that raises pwr_valid.
  task automatic expect_pv(input string tag, input longint pwr, input bit lk, input bit sat);
    int     waited = 0;
    longint last;
    while (pvq.size() == 0 && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    check_val({tag, "_pv_seen"}, longint'(pvq.size() > 0), 1);
    if (pvq.size() == 0) return;
    last_rec = pvq.pop_front();
    last     = (lastq.size() > 0) ? lastq.pop_front() : -100;
    check_val({tag, "_latency"}, last_rec.cyc - last, 1);
    check_val({tag, "_pwr"},     last_rec.pwr, pwr);
    check_val({tag, "_locked"},  longint'(last_rec.lk), longint'(lk));
    check_val({tag, "_sat"},     longint'(last_rec.sat), longint'(sat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    check_val("rst_pwr_out",   longint'(pwr_out), 0);
    check_val("rst_pwr_valid", longint'(pwr_valid), 0);
    check_val("rst_locked",    longint'(locked), 0);
    check_val("rst_sat",       longint'(sat_flag), 0);

    // 1: constant 8192 at reference 16384, back-to-back, locks on the 3rd window
    drive(8192, 48, 1'b0);
    expect_pv("t1_w1", P8192, 1'b0, 1'b0);
    expect_pv("t1_w2", P8192, 1'b0, 1'b0);
    expect_pv("t1_w3", P8192, 1'b1, 1'b0);

    // 2: single miss keeps lock, a hit clears it, two misses unlock
    drive(4096, 16, 1'b0);
    drive(8192, 16, 1'b0);
    drive(4096, 32, 1'b0);
    expect_pv("t2_miss1", P4096, 1'b1, 1'b0);
    expect_pv("t2_hit",   P8192, 1'b1, 1'b0);
    expect_pv("t2_miss2", P4096, 1'b1, 1'b0);
    expect_pv("t2_miss3", P4096, 1'b0, 1'b0);

    // 3: gapped full-scale negative window, max-code window, gapped ramp
    drive(-32768, 16, 1'b1);
    expect_pv("t3_min", PMIN, 1'b0, 1'b1);
    drive(0, 15, 1'b0);
    drive(32767, 1, 1'b0);
    expect_pv("t3_max", PMAX1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(i, 1, 1'b1);
    expect_pv("t3_ramp", PRAMP, 1'b0, 1'b0);

    // Tolerance edges around ref_pwr = 2^26 (tol = 2^22)
    drive(8444, 16, 1'b0);
    drive(7932, 16, 1'b0);
    drive(8444, 16, 1'b0);
    expect_pv("tol_hi_in1", P8444, 1'b0, 1'b0);
    expect_pv("tol_lo_in",  P7932, 1'b0, 1'b0);
    expect_pv("tol_hi_in2", P8444, 1'b1, 1'b0);
    drive(8445, 16, 1'b0);
    drive(8192, 16, 1'b0);
    drive(7931, 16, 1'b0);
    drive(8445, 16, 1'b0);
    expect_pv("tol_hi_out1", P8445, 1'b1, 1'b0);
    expect_pv("tol_exact",   P8192, 1'b1, 1'b0);
    expect_pv("tol_lo_out",  P7931, 1'b1, 1'b0);
    expect_pv("tol_hi_out2", P8445, 1'b0, 1'b0);

    // 4: lock, change reference mid-window, relock at the new target
    drive(8192, 48, 1'b0);
    expect_pv("t4_lock1", P8192, 1'b0, 1'b0);
    expect_pv("t4_lock2", P8192, 1'b0, 1'b0);
    expect_pv("t4_lock3", P8192, 1'b1, 1'b0);
    drive(8192, 8, 1'b0);
    reference = 16'd8192;
    drive(8192, 8, 1'b0);
    expect_pv("t4_refchg", P8192, 1'b0, 1'b0);
    drive(4096, 48, 1'b0);
    expect_pv("t4_relock1", P4096, 1'b0, 1'b0);
    expect_pv("t4_relock2", P4096, 1'b0, 1'b0);
    expect_pv("t4_relock3", P4096, 1'b1, 1'b0);

    // 5: reset after sample 10 discards the partial window
    drive(4096, 10, 1'b0);
    do_reset();
    check_val("t5_rst_pwr_out",   longint'(pwr_out), 0);
    check_val("t5_rst_pwr_valid", longint'(pwr_valid), 0);
    check_val("t5_rst_locked",    longint'(locked), 0);
    check_val("t5_rst_sat",       longint'(sat_flag), 0);
    drive(4096, 15, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_val("t5_no_early_pv", longint'(pvq.size()), 0);
    drive(4096, 1, 1'b0);
    expect_pv("t5_fresh", P4096, 1'b0, 1'b0);

    // reference == 0: silent windows hit (first one forced miss by the change)
    reference = 16'd0;
    drive(0, 64, 1'b0);
    expect_pv("z_refchg", 0, 1'b0, 1'b0);
    expect_pv("z_hit1",   0, 1'b0, 1'b0);
    expect_pv("z_hit2",   0, 1'b0, 1'b0);
    expect_pv("z_lock",   0, 1'b1, 1'b0);
    drive(1, 32, 1'b0);
    expect_pv("z_miss1", 1, 1'b1, 1'b0);
    expect_pv("z_miss2", 1, 1'b0, 1'b0);

`ifdef AGC_PWR_PEAK_EN
    // 6: peak magnitude, including the clamped most-negative code
    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0:       drive(100, 1, 1'b0);
        1:       drive(-3000, 1, 1'b0);
        default: drive(2500, 1, 1'b0);
      endcase
    end
    expect_pv("t6_peakwin", 4769375, 1'b0, 1'b0);
    check_val("t6_peak", longint'(last_rec.peak), 3000);
    drive(-32768, 16, 1'b0);
    expect_pv("t6_minwin", PMIN, 1'b0, 1'b1);
    check_val("t6_peak_min", longint'(last_rec.peak), 32767);
`endif

    repeat (8) @(posedge clk);
    #1;
    check_val("no_extra_pv", longint'(pvq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
